// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_ctrl_pkg
// Brief   : Shared types and helpers for the NTT memory control sequencer:
//           addressing modes, FSM states, stage decode, rotation amount.
// Rev     : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

  // Addressing / shift mode of one stage pass.
  typedef enum logic [1:0] {
    MODE_0 = 2'd0,  // all banks same address, cs2 steps down by SHIFT_M0
    MODE_1 = 2'd1,  // staggered addresses counting up, cs2 steps up by SHIFT_M1
    MODE_2 = 2'd2   // inverse: staggered addresses counting down, cs2 steps down
  } mode_t;

  // Pass sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Stage number to mode: 0 -> mode 0, 1/2 -> mode 1, 3 -> mode 2.
  function automatic mode_t stage_to_mode(input logic [1:0] stage);
    case (stage)
      2'd0:    return MODE_0;
      2'd3:    return MODE_2;
      default: return MODE_1;
    endcase
  endfunction

  // Write-enable rotation per step; constant, evaluated at elaboration.
  function automatic int rot_amount(input int size, input int shift_m1);
    return (size - shift_m1) % size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bank_addr_counter.sv
`default_nettype none
// ============================================================================
// Module  : bank_addr_counter
// Brief   : Loadable modulo-DEPTH up/down counter producing one bank address.
//           Load selects either zero or the elaboration-time offset INIT.
// Rev     : 1.0  initial release
// ============================================================================
module bank_addr_counter #(
  parameter int DEPTH  = 85,
  parameter int ADDR_W = 8,
  parameter int INIT   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic              load_init,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] INIT_VAL = ADDR_W'(INIT % DEPTH);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  // Clear beats load beats count; count wraps in both directions at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_init ? INIT_VAL : '0;
    end else if (en) begin
      if (down) begin
        addr <= (addr == '0) ? LAST : addr - ONE;
      end else begin
        addr <= (addr == LAST) ? '0 : addr + ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_control_seq.sv
`default_nettype none
// ============================================================================
// Module  : mem_control_seq
// Brief   : Self-sequencing memory controller for the banked NTT datapath.
//           Issues DEPTH steps per pass: per-bank addresses, bank write
//           enables and the read/write crossbar shift amounts.
// Rev     : 1.0  initial release
// ============================================================================
module mem_control_seq
  import mem_ctrl_pkg::*;
#(
  parameter int SIZE        = 257,
  parameter int DEPTH       = 85,
  parameter int ADDR_W      = 8,
  parameter int SHIFT_W     = 9,
  parameter int SHIFT_M0    = 1,
  parameter int SHIFT_M1    = 255,
  parameter int WE_ONES     = 255,
  parameter int ADDR_STRIDE = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   soft_reset,
  input  logic                   start,
  input  logic [1:0]             stage,
  input  logic                   stall,
  output logic                   busy,
  output logic                   valid,
  output logic                   done,
  output logic [SIZE*ADDR_W-1:0] addr,
  output logic [SIZE-1:0]        we,
  output logic [SHIFT_W-1:0]     cs1_shift,
  output logic [SHIFT_W-1:0]     cs2_shift
);

  localparam int                ROT       = rot_amount(SIZE, SHIFT_M1);
  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] STEP_ONE  = ADDR_W'(1);
  localparam logic [SHIFT_W:0]  SIZE_X    = (SHIFT_W+1)'(SIZE);
  localparam logic [SHIFT_W:0]  M0_X      = (SHIFT_W+1)'(SHIFT_M0);
  localparam logic [SHIFT_W:0]  M1_X      = (SHIFT_W+1)'(SHIFT_M1);
  // Low WE_ONES bits set; a shift by SIZE (WE_ONES = 0) yields all zeros.
  localparam logic [SIZE-1:0]   WE_INIT   = {SIZE{1'b1}} >> (SIZE - WE_ONES);

  state_t             state;
  mode_t              mode;
  logic [ADDR_W-1:0]  step;
  logic [SIZE-1:0]    we_reg;
  logic [SHIFT_W-1:0] cs2_next;
  logic [SHIFT_W-1:0] cs1_next;
  logic [SHIFT_W:0]   cs2_ext;
  logic [SHIFT_W:0]   cs2_sum;
  logic               start_ok;
  logic               start_init;
  logic               count_down;

  // Rotate the write-enable pattern left (towards higher banks) by ROT.
  function automatic logic [SIZE-1:0] rot_left(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) begin
      r[(i + ROT) % SIZE] = v[i];
    end
    return r;
  endfunction

  // Rotate the write-enable pattern right (towards lower banks) by ROT.
  function automatic logic [SIZE-1:0] rot_right(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) begin
      r[i] = v[(i + ROT) % SIZE];
    end
    return r;
  endfunction

  // A step issues whenever the pass is running and not held.
  assign valid      = (state == ST_RUN) && !stall;
  assign start_ok   = (state == ST_IDLE) && start;
  assign start_init = (stage_to_mode(stage) != MODE_0);
  assign count_down = (mode == MODE_2);

  // Next write-crossbar shift modulo SIZE with a single correction; cs1 mirrors it.
  always_comb begin
    cs2_ext = {1'b0, cs2_shift};
    cs2_sum = '0;
    if (mode == MODE_1) begin
      cs2_sum  = cs2_ext + M1_X;
      cs2_next = (cs2_sum >= SIZE_X) ? SHIFT_W'(cs2_sum - SIZE_X) : SHIFT_W'(cs2_sum);
    end else begin
      cs2_sum  = cs2_ext - ((mode == MODE_0) ? M0_X : M1_X);
      cs2_next = cs2_sum[SHIFT_W] ? SHIFT_W'(cs2_sum + SIZE_X) : SHIFT_W'(cs2_sum);
    end
    cs1_next = (cs2_next == '0) ? '0 : SHIFT_W'(SIZE_X - {1'b0, cs2_next});
  end

  // Write enables are gated by valid; mode 0 writes every bank.
  always_comb begin
    we = '0;
    if (valid) begin
      we = (mode == MODE_0) ? {SIZE{1'b1}} : we_reg;
    end
  end

  // Pass sequencer: state, mode latch, step count, shifts and we pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mode      <= MODE_0;
      step      <= '0;
      cs2_shift <= '0;
      cs1_shift <= '0;
      we_reg    <= WE_INIT;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (soft_reset) begin
      state     <= ST_IDLE;
      mode      <= MODE_0;
      step      <= '0;
      cs2_shift <= '0;
      cs1_shift <= '0;
      we_reg    <= WE_INIT;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            mode      <= stage_to_mode(stage);
            step      <= '0;
            cs2_shift <= '0;
            cs1_shift <= '0;
            we_reg    <= WE_INIT;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            step      <= step + STEP_ONE;
            cs2_shift <= cs2_next;
            cs1_shift <= cs1_next;
            case (mode)
              MODE_1:  we_reg <= rot_left(we_reg);
              MODE_2:  we_reg <= rot_right(we_reg);
              default: we_reg <= we_reg;
            endcase
            if (step == LAST_STEP) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // One address counter per bank; modes 1 and 2 start at a per-bank offset.
  for (genvar b = 0; b < SIZE; b++) begin : g_bank
    bank_addr_counter #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .INIT   ((b * ADDR_STRIDE) % DEPTH)
    ) u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (soft_reset),
      .load      (start_ok),
      .load_init (start_init),
      .en        (valid),
      .down      (count_down),
      .addr      (addr[b*ADDR_W +: ADDR_W])
    );
  end

endmodule
`default_nettype wire

// File: doc/mem_control_seq.md
# mem_control_seq

Parametrised, self-sequencing memory controller for the non-power-of-two NTT datapath. It drives the per-bank addresses, the bank write enables and the two crossbar shift amounts for one stage pass of DEPTH steps, started by a start pulse. It adds three things: bank count, depth and shift constants are parameters; a third, inverse mode is available; a start/stall/done handshake steps the pass internally instead of waiting for an external per-step increment. It sits between the NTT top-level sequencer and the banked coefficient memory and crossbars.

## Interface
- SIZE, 257: number of banks (modulus for shifts and write-enable rotation).
- DEPTH, 85: words per bank; steps per pass.
- ADDR_W, 8: per-bank address width; at least clog2(DEPTH).
- SHIFT_W, 9: shift width; at least clog2(SIZE).
- SHIFT_M0, 1: per-step cs2 decrement in mode 0.
- SHIFT_M1, 255: per-step cs2 increment in mode 1 and decrement in mode 2; less than SIZE.
- WE_ONES, 255: count of low write-enable bits set at pass start; at most SIZE.
- ADDR_STRIDE, 1: per-bank address offset in modes 1 and 2.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous clear, active-high; same effect as reset.
- start  in  1  begin a pass; only sampled in IDLE.
- stage  in  2  sampled with start: 0 selects mode 0, 1 or 2 selects mode 1, 3 selects mode 2.
- stall  in  1  hold the current step.
- busy  out  1  high in RUN and DONE.
- valid  out  1  current step is issued: high in RUN when stall is 0.
- done  out  1  one-cycle pulse after the last step.
- addr  out  SIZE*ADDR_W  bank b occupies bits [b*ADDR_W +: ADDR_W].
- we  out  SIZE  bank write enables.
- cs1_shift  out  SHIFT_W  read-crossbar shift.
- cs2_shift  out  SHIFT_W  write-crossbar shift.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on start. The mode is latched and all counters are reinitialised.
  - RUN to DONE when step DEPTH-1 is accepted.
  - DONE to IDLE unconditionally.
  - start is ignored outside IDLE. stage is ignored except on start.
- A step is accepted on each cycle where valid is 1. Acceptance advances the step counter, addr, cs2/cs1 and the we register at the next edge.
- Initial values at start:
  - step = 0, cs2 = 0, cs1 = 0.
  - we register has bits [WE_ONES-1:0] = 1 and all others 0.
  - Mode 0: addr[b] = 0. Modes 1 and 2: addr[b] = (b*ADDR_STRIDE) mod DEPTH, computed at elaboration.
- Address advance per accepted step:
  - Modes 0 and 1: addr[b] = (addr[b]+1) mod DEPTH.
  - Mode 2: addr[b] = (addr[b]-1) mod DEPTH, so 0 wraps to DEPTH-1.
- cs2 advance per accepted step:
  - Mode 0: (cs2 - SHIFT_M0) mod SIZE.
  - Mode 1: (cs2 + SHIFT_M1) mod SIZE.
  - Mode 2: (cs2 - SHIFT_M1) mod SIZE.
  - Compute in SHIFT_W+1 bits with one conditional correction; no divider.
- cs1 is registered together with cs2 as (SIZE - next_cs2) mod SIZE, so cs1 is 0 exactly when cs2 is 0.
- we register advance per accepted step:
  - Mode 1: rotate left by R = (SIZE - SHIFT_M1) mod SIZE.
  - Mode 2: rotate right by R.
  - Mode 0: held.
- we output:
  - 0 when valid is 0.
  - All ones in mode 0.
  - The we register in modes 1 and 2.
- After DONE, addr, cs1 and cs2 hold their post-advance values until the next start.

## Timing
- Reset values: state IDLE; busy, valid and done 0; addr all 0; cs1 and cs2 0; we 0; we register at the start pattern.
- start sampled at edge t gives RUN from cycle t+1, with valid=1 (if stall=0) and outputs at their step-0 values.
- With no stall, the pass takes DEPTH cycles in RUN, then done=1 for one cycle, then IDLE. A new start is accepted in the cycle after done.
- stall is combinational onto valid and we only; it does not feed any register path except as an enable.
- reset_n low at any time clears everything asynchronously. soft_reset clears at the next edge and overrides start and stall. A pass interrupted mid-way is abandoned with no done pulse.
- start together with soft_reset: soft_reset wins; the controller stays in IDLE.

## Structure
- Package mem_ctrl_pkg holds:
  - the mode and state enums;
  - the stage-to-mode decode function;
  - the constant rotation-amount function R(SIZE, SHIFT_M1).
- Sub-module bank_addr_counter: one per bank via generate. It is a loadable modulo-DEPTH up/down counter with parameter INIT.
- Shift and write-enable logic stay in the top module.

## Test plan
- Mode 1, defaults, no stall: cs2 goes 0, 255, 253, 251; cs1 goes 0, 2, 4, 6. After step 0, we has bits 256..2 = 1 and bits 1..0 = 0. done asserts exactly 85 cycles after RUN entry.
- Mode 0: cs2 goes 0, 256, 255; cs1 goes 0, 1, 2. we is all ones while valid. addr[b] = 84 for every bank on the last step.
- Mode 2: cs2 goes 0, 2, 4. After one step we has bits 254..253 = 0 and all others 1. addr[0] goes 0 then 84.
- Mode 1 initial addresses: addr[86] = 1 at step 0. stall held 3 cycles mid-pass gives valid=0 and we=0, outputs frozen, and done delayed by exactly 3 cycles.
- start while busy is ignored. soft_reset at step 40 returns to IDLE with no done pulse and reset values on all outputs.
- reset_n asserted mid-pass clears immediately. After release, a new start runs a full 85-step pass.
